// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of the asynchronous FIFO: binary/Gray write pointers, read-pointer synchroniser,
// registered full flag, fill level and sticky overflow. Optional almost-full output under FIFO_WR_AFULL_EN.
module fifo_wr_ctrl #(
    parameter int PTR_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             winc,
    input  logic [PTR_W-1:0] rptr_gray,
    input  logic             wovf_clr,
    output logic [PTR_W-2:0] waddr,
    output logic [PTR_W-1:0] wptr_gray,
    output logic             wfull,
    output logic [PTR_W-1:0] wlevel,
    output logic             wovf
`ifdef FIFO_WR_AFULL_EN
    ,
    output logic             wafull
`endif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("fifo_wr_ctrl: SYNC_STAGES must be 2..4");
    end
    if (PTR_W < 3 || AF_THRESH < 1 || AF_THRESH > (1 << (PTR_W - 1))) begin : g_bad_af
        $error("fifo_wr_ctrl: PTR_W must be >= 3 and AF_THRESH within 1..DEPTH");
    end

    logic [PTR_W-1:0] wbin_q,   wbin_d;
    logic [PTR_W-1:0] wgray_q,  wgray_d;
    logic             wfull_q,  wfull_d;
    logic [PTR_W-1:0] wlevel_q, wlevel_d;
    logic             wovf_q,   wovf_d;
    logic [PTR_W-1:0] rq_q [SYNC_STAGES];
    logic [PTR_W-1:0] rq_s;
    logic [PTR_W-1:0] rbin_s;
    logic             wacc;

    always_comb begin
        wacc    = winc & ~wfull_q;
        wbin_d  = wbin_q + PTR_W'(wacc);
        wgray_d = wbin_d ^ (wbin_d >> 1);

        rq_s   = rq_q[SYNC_STAGES-1];
        rbin_s = '0;
        rbin_s[PTR_W-1] = rq_s[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ rq_s[i];
        end

        // Full when the next write pointer laps the synchronised read pointer: top two Gray bits inverted.
        wfull_d  = (wgray_d == {~rq_s[PTR_W-1:PTR_W-2], rq_s[PTR_W-3:0]});
        wlevel_d = wbin_d - rbin_s;
        // A new overflow takes priority over a simultaneous clear so no event is lost.
        wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wfull_q  <= wfull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    // Plain flop chain for the clock-domain crossing; nothing may sit between stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                rq_q[k] <= '0;
            end
        end else begin
            rq_q[0] <= rptr_gray;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                rq_q[k] <= rq_q[k-1];
            end
        end
    end

    assign waddr     = wbin_q[PTR_W-2:0];
    assign wptr_gray = wgray_q;
    assign wfull     = wfull_q;
    assign wlevel    = wlevel_q;
    assign wovf      = wovf_q;

`ifdef FIFO_WR_AFULL_EN
    logic wafull_q, wafull_d;

    always_comb begin
        wafull_d = (wlevel_d >= PTR_W'(AF_THRESH));
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign wafull = wafull_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl (PTR_W=4, SYNC_STAGES=2): occupancy-count reference model with directed and random stimulus.
module tb_fifo_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] rptr_gray = '0;
    logic       wovf_clr = 1'b0;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wfull;
    logic [3:0] wlevel;
    logic       wovf;
`ifdef FIFO_WR_AFULL_EN
    logic       wafull;
`endif

    fifo_wr_ctrl #(.PTR_W(4), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .winc      (winc),
        .rptr_gray (rptr_gray),
        .wovf_clr  (wovf_clr),
        .waddr     (waddr),
        .wptr_gray (wptr_gray),
        .wfull     (wfull),
        .wlevel    (wlevel),
        .wovf      (wovf)
`ifdef FIFO_WR_AFULL_EN
        ,
        .wafull    (wafull)
`endif
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int failures = 0;

    // Reference model: counts of accepted writes and issued reads; read count seen two edges late.
    int m_wr = 0;
    int m_rd = 0;
    int s0 = 0;
    int s1 = 0;
    bit m_full = 0;
    bit m_ovf = 0;
    bit m_afull = 0;
    int m_level = 0;

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = 4'(v % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic step(input bit w, input bit clr);
        bit full_prev;
        int rd_s;
        winc      = w;
        wovf_clr  = clr;
        rptr_gray = gray4(m_rd);
        @(posedge wclk);
        #1;
        full_prev = m_full;
        rd_s = s1;
        s1 = s0;
        s0 = m_rd;
        if (w && !full_prev) m_wr++;
        m_ovf   = (w && full_prev) || (m_ovf && !clr);
        m_level = m_wr - rd_s;
        m_full  = (m_level == 8);
        m_afull = (m_level >= 6);
    endtask

    task automatic apply_reset();
        winc = 0; wovf_clr = 0; rptr_gray = '0;
        wrst_n = 0;
        m_wr = 0; m_rd = 0; s0 = 0; s1 = 0;
        m_full = 0; m_ovf = 0; m_afull = 0; m_level = 0;
        @(negedge wclk);
        @(negedge wclk);
        wrst_n = 1;
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({waddr, wptr_gray, wfull, wlevel, wovf} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state got waddr=%0d gray=%b full=%b level=%0d ovf=%b want all zero",
                     waddr, wptr_gray, wfull, wlevel, wovf);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (waddr !== 3'(i)) begin
                failures++;
                $display("FAIL fill_waddr[%0d] got %0d want %0d", i, waddr, i);
            end
            checks++;
            if (wfull !== 1'b0) begin
                failures++;
                $display("FAIL fill_early_full[%0d] got %b want 0", i, wfull);
            end
            step(1, 0);
        end
        checks++;
        if (wfull !== 1'b1 || wfull !== m_full) begin
            failures++;
            $display("FAIL fill_full got %b want 1", wfull);
        end
        checks++;
        if (wlevel !== 4'd8) begin
            failures++;
            $display("FAIL fill_level got %0d want 8", wlevel);
        end
        checks++;
        if (wptr_gray !== 4'b1100) begin
            failures++;
            $display("FAIL fill_gray got %b want 1100", wptr_gray);
        end
    endtask

    task automatic test_overflow();
        step(1, 0);
        step(1, 0);
        checks++;
        if (waddr !== 3'd0 || wptr_gray !== 4'b1100 || wfull !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold got waddr=%0d gray=%b full=%b want 0 1100 1", waddr, wptr_gray, wfull);
        end
        checks++;
        if (wovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got %b want 1", wovf);
        end
        step(1, 1);
        checks++;
        if (wovf !== 1'b1 || wovf !== m_ovf) begin
            failures++;
            $display("FAIL ovf_set_wins got %b want 1", wovf);
        end
        step(0, 1);
        checks++;
        if (wovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got %b want 0", wovf);
        end
    endtask

    task automatic test_drain();
        m_rd = 1;
        for (int c = 1; c <= 3; c++) begin
            step(0, 0);
            checks++;
            if (wfull !== ((c < 3) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL drain_full[cycle %0d] got %b want %b", c, wfull, (c < 3));
            end
        end
        checks++;
        if (wlevel !== 4'd7 || int'(wlevel) != m_level) begin
            failures++;
            $display("FAIL drain_level got %0d want 7", wlevel);
        end
    endtask

    task automatic test_reset_midstream();
        step(1, 0);
        step(1, 0);
        checks++;
        if (wfull !== 1'b1 || wovf !== 1'b1) begin
            failures++;
            $display("FAIL refill got full=%b ovf=%b want 1 1", wfull, wovf);
        end
        winc = 1;
        wrst_n = 0;
        #1;
        checks++;
        if ({waddr, wptr_gray, wfull, wlevel, wovf} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset got waddr=%0d gray=%b full=%b level=%0d ovf=%b want all zero",
                     waddr, wptr_gray, wfull, wlevel, wovf);
        end
        apply_reset();
    endtask

    task automatic test_wrap();
        int cyc = 0;
        while (m_wr < 20 && cyc < 400) begin
            bit w;
            w = ((m_wr - m_rd) < 2) && ($urandom_range(0, 3) != 0);
            if (m_rd < m_wr && $urandom_range(0, 1) == 1) m_rd++;
            step(w, 0);
            cyc++;
            checks++;
            if (wfull !== 1'b0 || int'(wlevel) != m_level || waddr !== 3'(m_wr % 8) ||
                wptr_gray !== gray4(m_wr)) begin
                failures++;
                $display("FAIL wrap[%0d] got full=%b level=%0d waddr=%0d gray=%b want 0 %0d %0d %b",
                         cyc, wfull, wlevel, waddr, wptr_gray, m_level, m_wr % 8, gray4(m_wr));
            end
        end
        checks++;
        if (m_wr < 20) begin
            failures++;
            $display("FAIL wrap_budget got %0d writes want 20", m_wr);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit w, clr;
            w   = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 7) == 0);
            if (m_rd < m_wr && $urandom_range(0, 2) == 0) m_rd++;
            step(w, clr);
            checks++;
            if (wfull !== m_full || int'(wlevel) != m_level || wovf !== m_ovf ||
                waddr !== 3'(m_wr % 8) || wptr_gray !== gray4(m_wr)) begin
                failures++;
                $display("FAIL random[%0d] got full=%b level=%0d ovf=%b waddr=%0d gray=%b want %b %0d %b %0d %b",
                         cyc, wfull, wlevel, wovf, waddr, wptr_gray, m_full, m_level, m_ovf, m_wr % 8, gray4(m_wr));
            end
        end
    endtask

`ifdef FIFO_WR_AFULL_EN
    task automatic test_afull();
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1, 0);
            checks++;
            if (wafull !== ((i >= 6) ? 1'b1 : 1'b0) || wafull !== m_afull) begin
                failures++;
                $display("FAIL afull_fill[%0d] got %b want %b", i, wafull, (i >= 6));
            end
        end
        checks++;
        if (wlevel !== 4'd6) begin
            failures++;
            $display("FAIL afull_level got %0d want 6", wlevel);
        end
        m_rd = 1;
        for (int c = 1; c <= 3; c++) begin
            step(0, 0);
            checks++;
            if (wafull !== ((c < 3) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL afull_drain[cycle %0d] got %b want %b", c, wafull, (c < 3));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_reset_midstream();
        test_wrap();
        apply_reset();
        test_random();
`ifdef FIFO_WR_AFULL_EN
        test_afull();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
